// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-setting controller for a 190 Hz clock.
// The mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN. The up button
// increments the selected field, and auto-repeats while it is held. The exit
// button clears seconds in RUN, or leaves a set mode.
// Optional feature: define TIME_SET_TIMEOUT_EN to abandon a set mode after
// TIMEOUT_TICKS idle cycles. Without it, no idle counter is built.
// Handshake: there is none. btn_in is a debounced level. Every output is a
// registered level or a one-cycle pulse that appears one cycle after the
// input edge that caused it.
module time_set_ctrl #(
  parameter int HOLD_TICKS    = 190,
  parameter int REPEAT_TICKS  = 19,
  parameter int TIMEOUT_TICKS = 1900
) (
  input  logic       clk190,
  input  logic       rst,
  input  logic [2:0] btn_in,
  output logic [1:0] mode,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [15:0] HOLD_T = 16'(HOLD_TICKS);
  localparam logic [15:0] REP_T  = 16'(REPEAT_TICKS);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  btn_d;
  logic [2:0]  rise;
  logic        in_set;
  logic        held;
  logic        state_change;
  logic        auto_fire;
  logic [15:0] hold_cnt;
  logic [15:0] hold_inc;
  logic [15:0] hold_nxt;
  logic [15:0] rep_cnt;
  logic [15:0] rep_nxt;
  logic        inc_hour_nxt;
  logic        inc_min_nxt;
  logic        clr_sec_nxt;
  logic        timeout_hit;

  assign rise   = btn_in & ~btn_d;
  assign in_set = (state != RUN);
  assign held   = in_set & btn_in[1];

  // The hold counter saturates so an endless hold keeps repeating and never wraps.
  assign hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;

  // The first auto pulse fires when the hold count reaches HOLD_TICKS. After
  // that, rep_cnt paces one pulse every REPEAT_TICKS cycles.
  assign auto_fire = held & ((hold_inc == HOLD_T) |
                             ((hold_cnt >= HOLD_T) & (rep_cnt == REP_T - 16'd1)));

`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_T = 16'(TIMEOUT_TICKS);
  logic [15:0] idle_cnt;
  logic [15:0] idle_inc;
  logic [15:0] idle_nxt;

  assign idle_inc    = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
  assign timeout_hit = in_set & (btn_in == 3'b000) & (idle_inc == TIMEOUT_T);
  assign idle_nxt    = (state_change || !in_set || btn_in != 3'b000) ? 16'd0 : idle_inc;

  // Idle counter: it runs only in a set mode while no button is pressed.
  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) idle_cnt <= 16'd0;
    else     idle_cnt <= idle_nxt;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state. Exit beats mode, and mode beats timeout. Up never changes state.
  always_comb begin
    state_nxt = state;
    if (rise[2]) begin
      state_nxt = RUN;
    end else if (rise[0]) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        default:  state_nxt = RUN;
      endcase
    end else if (timeout_hit) begin
      state_nxt = RUN;
    end
  end

  assign state_change = (state_nxt != state);

  // Pulses. Any state change swallows up events, so at most one pulse is high.
  always_comb begin
    inc_hour_nxt = 1'b0;
    inc_min_nxt  = 1'b0;
    clr_sec_nxt  = 1'b0;
    if (rise[2] && state == RUN) begin
      clr_sec_nxt = 1'b1;
    end else if (!state_change && (rise[1] || auto_fire)) begin
      if (state == SET_HOUR)     inc_hour_nxt = 1'b1;
      else if (state == SET_MIN) inc_min_nxt  = 1'b1;
    end
  end

  // A state change or a released button clears the hold and repeat counters.
  always_comb begin
    hold_nxt = hold_inc;
    rep_nxt  = rep_cnt + 16'd1;
    if (state_change || !held) begin
      hold_nxt = 16'd0;
      rep_nxt  = 16'd0;
    end else if (hold_cnt < HOLD_T || auto_fire) begin
      rep_nxt = 16'd0;
    end
  end

  // Button history plus the hold and repeat counters
  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) begin
      btn_d    <= 3'b000;
      hold_cnt <= 16'd0;
      rep_cnt  <= 16'd0;
    end else begin
      btn_d    <= btn_in;
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
    end
  end

  // Registered outputs. mode and blink track the next state, so they update
  // on the same edge as the state register.
  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) begin
      mode     <= 2'b00;
      blink    <= 1'b0;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      clr_sec  <= 1'b0;
    end else begin
      mode     <= state_nxt;
      blink    <= (state_nxt != RUN);
      inc_hour <= inc_hour_nxt;
      inc_min  <= inc_min_nxt;
      clr_sec  <= clr_sec_nxt;
    end
  end

endmodule
